// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble binary-to-BCD converter, one bit per cycle.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blank mask output.
module bin2bcd_seq #(
   parameter int WIDTH  = 25,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      abs_num,
   input  logic                  neg_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg_out
`ifdef BIN2BCD_BLANK_EN
  ,output logic [DIGITS-1:0]     blank
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [4*DIGITS-1:0] scr_q, scr_d, adj, bcd_q, bcd_d;
   logic                neg_q, neg_d, nout_q, nout_d, done_q, done_d;
   always_comb begin
      adj = scr_q;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i+:4] = (scr_q[4*i+:4] >= 4'd5) ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      neg_d   = neg_q;
      bcd_d   = bcd_q;
      nout_d  = nout_q;
      done_d  = 1'b0;
      if (state_q == S_IDLE && start) begin
         state_d = S_SHIFT;
         bin_d   = abs_num;
         neg_d   = neg_in;
         scr_d   = '0;
         cnt_d   = '0;
      end else if (state_q == S_SHIFT) begin
         {scr_d, bin_d} = {adj, bin_q} << 1;
         cnt_d   = cnt_q + 1'b1;
         state_d = (cnt_q == CW'(WIDTH - 1)) ? S_DONE : S_SHIFT;
      end else if (state_q == S_DONE) begin
         bcd_d   = scr_q;
         nout_d  = neg_q;
         done_d  = 1'b1;
         state_d = S_IDLE;
      end else begin
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         scr_q   <= '0;
         neg_q   <= 1'b0;
         bcd_q   <= '0;
         nout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         neg_q   <= neg_d;
         bcd_q   <= bcd_d;
         nout_q  <= nout_d;
         done_q  <= done_d;
      end
   end
   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign bcd     = bcd_q;
   assign neg_out = nout_q;
`ifdef BIN2BCD_BLANK_EN
   // digit 0 is never blanked so a zero value still shows a single 0
   logic [DIGITS-1:0] blank_q, zero_up;
   assign zero_up[0] = 1'b0;
   for (genvar g = 1; g < DIGITS; g++) begin : g_blank
      assign zero_up[g] = ~|scr_q[4*DIGITS-1:4*g];
   end
   always_ff @(posedge clk) begin
      if (!rst_n)
         blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      else if (state_q == S_DONE)
         blank_q <= zero_up;
   end
   assign blank = blank_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq (defaults WIDTH=25, DIGITS=8).
module tb_bin2bcd_seq;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, neg_in = 1'b0;
   logic [24:0] abs_num = '0;
   logic        busy, done, neg_out;
   logic [31:0] bcd;
`ifdef BIN2BCD_BLANK_EN
   logic [7:0]  blank;
`endif
   int n_chk = 0, n_fail = 0;
   int lat, dones, first, second;

   always #5 clk = ~clk;

   bin2bcd_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abs_num(abs_num), .neg_in(neg_in),
      .busy(busy), .done(done), .bcd(bcd), .neg_out(neg_out)
`ifdef BIN2BCD_BLANK_EN
     ,.blank(blank)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_blank(input string tag, input logic [7:0] exp);
`ifdef BIN2BCD_BLANK_EN
      chk(tag, blank, exp);
`endif
   endtask

   // start one conversion; optionally disturb inputs after chg_at cycles; returns cycles to done
   task automatic conv(input logic [24:0] val, input logic neg, input int chg_at,
                       input logic [24:0] chg_val, output int l);
      abs_num = val;
      neg_in  = neg;
      start   = 1'b1;
      tick;
      start   = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      l = 0;
      while (!done && l < 40) begin
         if (l == chg_at) begin
            abs_num = chg_val;
            neg_in  = ~neg;
         end
         tick;
         l++;
      end
   endtask

   task automatic expect_res(input string tag, input int l, input logic [31:0] eb,
                             input logic en, input logic [7:0] ebl);
      chk({tag, "_latency"}, l, 26);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_low"}, busy, 1'b0);
      chk({tag, "_bcd"}, bcd, eb);
      chk({tag, "_neg"}, neg_out, en);
      chk_blank({tag, "_blank"}, ebl);
      tick;
      chk({tag, "_done_pulse"}, done, 1'b0);
      chk({tag, "_bcd_hold"}, bcd, eb);
   endtask

   initial begin
      tick;
      tick;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_bcd", bcd, 32'h0);
      chk("rst_neg", neg_out, 1'b0);
      chk_blank("rst_blank", 8'b11111110);
      rst_n = 1'b1;
      tick;

      conv(25'd0, 1'b0, -1, '0, lat);
      expect_res("zero", lat, 32'h00000000, 1'b0, 8'b11111110);
      conv(25'd33554431, 1'b0, -1, '0, lat);
      expect_res("max", lat, 32'h33554431, 1'b0, 8'b00000000);
      conv(25'd12345, 1'b1, 5, 25'd999, lat);
      expect_res("chg", lat, 32'h00012345, 1'b1, 8'b11100000);
      conv(25'd10, 1'b0, -1, '0, lat);
      expect_res("ten", lat, 32'h00000010, 1'b0, 8'b11111100);
      conv(25'd9999999, 1'b1, -1, '0, lat);
      expect_res("nines", lat, 32'h09999999, 1'b1, 8'b10000000);
      conv(25'd0, 1'b1, -1, '0, lat);
      expect_res("minus0", lat, 32'h00000000, 1'b1, 8'b11111110);

      // start held high: conversions every WIDTH+2 cycles, none accepted while busy
      abs_num = 25'd7;
      neg_in  = 1'b0;
      start   = 1'b1;
      tick;
      dones = 0; first = -1; second = -1;
      for (int c = 1; c <= 60; c++) begin
         tick;
         if (c == 27) chk("held_restart_busy", busy, 1'b1);
         if (done) begin
            dones++;
            if (first < 0) first = c;
            else if (second < 0) second = c;
            chk("held_bcd", bcd, 32'h00000007);
            chk("held_busy_low", busy, 1'b0);
         end
      end
      start = 1'b0;
      chk("held_first", first, 26);
      chk("held_second", second, 53);
      chk("held_count", dones, 2);
      lat = 0;
      while (!done && lat < 40) begin
         tick;
         lat++;
      end
      chk("held_drain", done, 1'b1);
      tick;

      // reset in the middle of a conversion
      abs_num = 25'd555;
      neg_in  = 1'b1;
      start   = 1'b1;
      tick;
      start   = 1'b0;
      repeat (9) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_bcd", bcd, 32'h0);
      chk("abort_neg", neg_out, 1'b0);
      chk_blank("abort_blank", 8'b11111110);
      dones = 0;
      repeat (30) begin
         tick;
         if (done) dones++;
      end
      chk("abort_no_done", dones, 0);
      conv(25'd100, 1'b0, -1, '0, lat);
      expect_res("post_rst", lat, 32'h00000100, 1'b0, 8'b11111000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
